// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the regfile_2r1w register file.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer for regfile_2r1w: walks registers 1..DEPTH-1 one per cycle
// after a CLR pulse and reports BUSY while the sweep runs.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLR,
  output logic          busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_idx
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (CLR) begin
          state_d = SWEEP;
          ptr_d   = AW'(1);
        end
      end
      SWEEP: begin
        // Last entry cleared on this edge; re-arm the pointer for the next sweep.
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          ptr_d   = AW'(1);
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = AW'(1);
      end
    endcase
    busy_d = (state_d == SWEEP);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= AW'(1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign clr_en  = busy_q;
  assign clr_idx = ptr_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with one write port, two registered read ports, hardwired-zero
// register 0 and a hardware clear sweep. Define REGFILE_BYPASS_EN for write-through.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [AW-1:0]    WSEL,
  input  logic [WIDTH-1:0] WDATA,
  input  logic [AW-1:0]    RSEL_A,
  input  logic [AW-1:0]    RSEL_B,
  output logic [WIDTH-1:0] RDATA_A,
  output logic [WIDTH-1:0] RDATA_B,
  input  logic             CLR,
  output logic             BUSY
);

  logic             busy;
  logic             clr_en;
  logic [AW-1:0]    clr_idx;
  logic             wr_en;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0] rdata_b_q, rdata_b_d;

  regfile_clr_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_seq (
    .CLK     (CLK),
    .RST     (RST),
    .CLR     (CLR),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  // A clear request in the same cycle wins over the write.
  assign wr_en = WE && !busy && !CLR && (WSEL != '0);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[WSEL] = WDATA;
    end
    if (clr_en) begin
      mem_d[clr_idx] = '0;
    end
    mem_d[0] = '0;
  end

`ifdef REGFILE_BYPASS_EN
  // Reading the next-state view forwards the accepted write and the sweep's zero.
  always_comb begin
    rdata_a_d = mem_d[RSEL_A];
    rdata_b_d = mem_d[RSEL_B];
  end
`else
  always_comb begin
    rdata_a_d = mem_q[RSEL_A];
    rdata_b_d = mem_q[RSEL_B];
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign RDATA_A = rdata_a_q;
  assign RDATA_B = rdata_b_q;
  assign BUSY    = busy;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w (WIDTH=16, DEPTH=8).
module tb_regfile_2r1w;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             WE = 1'b0;
  logic [AW-1:0]    WSEL = '0;
  logic [WIDTH-1:0] WDATA = '0;
  logic [AW-1:0]    RSEL_A = '0;
  logic [AW-1:0]    RSEL_B = '0;
  logic [WIDTH-1:0] RDATA_A;
  logic [WIDTH-1:0] RDATA_B;
  logic             CLR = 1'b0;
  logic             BUSY;

  int n_assert = 0;
  int n_fail   = 0;

  regfile_2r1w #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .WE      (WE),
    .WSEL    (WSEL),
    .WDATA   (WDATA),
    .RSEL_A  (RSEL_A),
    .RSEL_B  (RSEL_B),
    .RDATA_A (RDATA_A),
    .RDATA_B (RDATA_B),
    .CLR     (CLR),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] sel, input logic [WIDTH-1:0] data);
    WE = 1'b1; WSEL = sel; WDATA = data;
    step();
    WE = 1'b0;
  endtask

  task automatic fill();
    for (int i = 1; i < DEPTH; i++) wr(AW'(i), WIDTH'(16'h1000 + i));
  endtask

  task automatic count_busy(input string tag);
    int cnt;
    cnt = (BUSY === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20 && BUSY === 1'b1; i++) begin
      step();
      if (BUSY === 1'b1) cnt++;
    end
    chk(tag, WIDTH'(cnt), WIDTH'(DEPTH - 1));
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      RSEL_A = AW'(i); RSEL_B = AW'(DEPTH - 1 - i);
      step();
      chk({tag, "_a"}, RDATA_A, '0);
      chk({tag, "_b"}, RDATA_B, '0);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] exp_fwd;

    // Reset state
    step(); step();
    chk("rst_busy", WIDTH'(BUSY), '0);
    chk("rst_rda", RDATA_A, '0);
    chk("rst_rdb", RDATA_B, '0);
    RST = 1'b0;
    step();
    check_all_zero("rst_read");

    // Write reg 3, attempt write to reg 0
    wr(3'd3, 16'h1234);
    wr(3'd0, 16'hBEEF);
    RSEL_A = 3'd3; RSEL_B = 3'd0;
    step();
    chk("wr3_a", RDATA_A, 16'h1234);
    chk("wr0_b", RDATA_B, 16'h0000);

    // Same-cycle write and read of reg 5
    wr(3'd5, 16'h0001);
    RSEL_A = 3'd5; RSEL_B = 3'd3;
    WE = 1'b1; WSEL = 3'd5; WDATA = 16'hA5A5;
    step();
    WE = 1'b0;
`ifdef REGFILE_BYPASS_EN
    exp_fwd = 16'hA5A5;
`else
    exp_fwd = 16'h0001;
`endif
    chk("same_cyc_a", RDATA_A, exp_fwd);
    chk("same_cyc_b", RDATA_B, 16'h1234);
    step();
    chk("after_wr_a", RDATA_A, 16'hA5A5);

    // Fill, then CLR with a competing write to reg 2
    fill();
    RSEL_A = 3'd2; RSEL_B = 3'd7;
    step();
    chk("fill_r2", RDATA_A, 16'h1002);
    chk("fill_r7", RDATA_B, 16'h1007);
    CLR = 1'b1; WE = 1'b1; WSEL = 3'd2; WDATA = 16'hFFFF;
    step();
    CLR = 1'b0; WE = 1'b0;
    chk("clr_busy_on", WIDTH'(BUSY), 16'd1);
    chk("clr_drop_wr", RDATA_A, 16'h1002);
    count_busy("sweep_len");
    check_all_zero("swept");

    // Write and second CLR during the sweep are ignored
    fill();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    step(); step(); step();
    WE = 1'b1; WSEL = 3'd6; WDATA = 16'h6666; CLR = 1'b1;
    step();
    WE = 1'b0; CLR = 1'b0;
    chk("mid_busy_k4", WIDTH'(BUSY), 16'd1);
    step(); step();
    chk("mid_busy_k6", WIDTH'(BUSY), 16'd1);
    step();
    chk("mid_busy_k7", WIDTH'(BUSY), 16'd0);
    RSEL_A = 3'd6; RSEL_B = 3'd5;
    step();
    chk("mid_r6", RDATA_A, 16'h0000);
    chk("mid_r5", RDATA_B, 16'h0000);
    wr(3'd6, 16'h0600);
    step();
    chk("post_sweep_wr", RDATA_A, 16'h0600);

    // Asynchronous reset in the middle of a sweep
    wr(3'd7, 16'h7777);
    RSEL_A = 3'd7; RSEL_B = 3'd7;
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    chk("pre_rst_a", RDATA_A, 16'h7777);
    chk("pre_rst_busy", WIDTH'(BUSY), 16'd1);
    step(); step();
    #2 RST = 1'b1;
    #1;
    chk("arst_busy", WIDTH'(BUSY), '0);
    chk("arst_rda", RDATA_A, '0);
    chk("arst_rdb", RDATA_B, '0);
    #1 RST = 1'b0;
    step();
    chk("arst_r7", RDATA_A, '0);
    chk("arst_idle", WIDTH'(BUSY), '0);
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    count_busy("resweep_len");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
